pipe_interlock: RTL and testbench
=================================

# pipe_interlock

Pipeline interlock controller for the 5-stage MIPS core. Forwarding resolves most ID-stage operand hazards; this block handles the cases it cannot:
- a load still in EX feeding an instruction in ID;
- the multi-cycle multiply/divide unit still busy when the ID instruction needs HI/LO or a new mult/div.

It freezes PC and IF/ID, injects a bubble into ID/EX, and tracks multiply/divide occupancy with an internal countdown. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters
- MD_LAT, 32: multiply/divide occupancy in cycles after issue (legal 1..63).
- CNT_W, 32: stall counter width.

Ports
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_id  in  6  opcode of the instruction in ID.
- func_id  in  6  funct field of the instruction in ID.
- Rs_id  in  5  rs of the instruction in ID.
- Rt_id  in  5  rt of the instruction in ID.
- op_ex  in  6  opcode of the instruction in EX.
- Rw_ex  in  5  destination register of the instruction in EX.
- flush  in  1  the ID instruction is squashed this cycle (taken branch/jump redirect).
- pc_wr  out  1  PC write enable; 0 = hold.
- ifid_wr  out  1  IF/ID write enable; 0 = hold.
- idex_bubble  out  1  ID/EX loads a NOP (op 0, Rw 0, RegWr 0).
- md_start  out  1  one-cycle pulse: a mult/div is issued from ID to EX this cycle.
- md_busy  out  1  multiply/divide unit occupied (countdown non-zero).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
Instruction classes (decoded from op_id/func_id):
- BR: beq 000100, bne 000101, regimm 000001, blez 000110, bgtz 000111, jr (000000/001000), jalr (000000/001001).
- MD: op 000000 with func 011000..011011 (mult, multu, div, divu).
- HL: op 000000 with func 010000 (mfhi) or 010010 (mflo).
- Uses_rt: beq, bne, any other op 000000 R-type except HL and jr/jalr, and sw 101011.

Hazard terms:
- ld_haz = (op_ex == 100011) && (Rw_ex != 0) && ((Rs_id == Rw_ex) || (Uses_rt && Rt_id == Rw_ex)).
  - Applies to every ID instruction that reads rs; BR and ALU consumers alike.
  - A load in MEM is handled by forwarding, not here.
- md_haz = md_busy && (MD || HL).
- stall = (ld_haz || md_haz) && !flush.

Outputs:
- pc_wr = ifid_wr = !stall.
- idex_bubble = stall || flush.
- md_start = MD && !stall && !flush.

MD countdown (md_cnt, 6 bits):
- On the md_start edge, md_cnt ← MD_LAT.
- Otherwise, if md_cnt != 0, md_cnt decrements.
- md_busy = (md_cnt != 0).
- md_start cannot coincide with md_cnt != 0, because md_haz would stall.

Stall counter:
- stall_cnt increments each cycle stall = 1.
- It saturates at all-ones and never wraps.

Boundaries:
- ld_haz and md_haz together: a single stall cycle is counted. When ld_haz clears, md_haz keeps the stall alone.
- flush overrides stall. The squashed instruction is bubbled and never counted. md_start is suppressed, so the countdown is not loaded.
- Rw_ex = 0 never stalls. This guarantees the injected bubble cannot self-stall.
- Reset mid-countdown: md_cnt → 0 immediately and md_busy falls the next cycle.

## Timing
- Reset values (rst high at an edge): md_cnt = 0 and stall_cnt = 0. As a result pc_wr = 1, ifid_wr = 1, idex_bubble = 0, md_start = 0, md_busy = 0, provided the combinational inputs show no hazard.
- Hazard outputs are combinational from current inputs and state; they take effect at the same edge the hazard is seen.
- Load-use costs exactly 1 stall cycle:
  - Cycle N: ld_haz is seen and the bubble enters EX.
  - Cycle N+1: the load is in MEM, the NOP is in EX, and ID proceeds using MEM forwarding.
- MD issue at cycle N gives md_busy = 1 for cycles N+1 .. N+MD_LAT.
  - An HL or MD instruction in ID at cycle N+k (1 ≤ k ≤ MD_LAT) stalls until cycle N+MD_LAT inclusive.
  - It proceeds at cycle N+MD_LAT+1.
- stall_cnt updates one edge after the stalled cycle.

## Test plan
- Load-use on branch: op_ex=100011, Rw_ex=5; op_id=000100, Rs_id=5 → pc_wr=ifid_wr=0, idex_bubble=1 for exactly 1 cycle; stall_cnt 0→1.
- Load with Rw_ex=0 and Rs_id=0 → no stall. Load to r5 while ID is an ALU op that uses only rt=5 via an I-type addi (rt is its destination) → no stall.
- MD latency, MD_LAT=4: mult issued at cycle 10 (md_start=1), then mfhi in ID at cycle 11 → stall on cycles 11–14, proceed at cycle 15; md_busy is 1 on cycles 11–14; stall_cnt = 4.
- Back-to-back mult at cycle 10 and div in ID at cycle 11 with MD_LAT=4 → div stalls until md_busy drops; md_start pulses at cycle 15 and md_cnt reloads to 4.
- flush with ld_haz in the same cycle → pc_wr=1, idex_bubble=1, stall_cnt unchanged. flush with a mult in ID → md_start=0, md_busy stays 0.
- rst asserted at md_cnt=3 with mfhi stalling → the next cycle has md_busy=0, stall_cnt=0, and mfhi proceeds. Separately, force stall_cnt to all-ones (CNT_W=4, 16 stalls) and verify it holds at 15.

Source files
------------

// File: rtl/pipe_interlock_if.sv
// rtl/pipe_interlock_if.sv - ID/EX hazard inputs and interlock control outputs
interface pipe_interlock_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op_id;
  logic [5:0]       func_id;
  logic [4:0]       Rs_id;
  logic [4:0]       Rt_id;
  logic [5:0]       op_ex;
  logic [4:0]       Rw_ex;
  logic             flush;
  logic             pc_wr;
  logic             ifid_wr;
  logic             idex_bubble;
  logic             md_start;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output op_id, func_id, Rs_id, Rt_id, op_ex, Rw_ex, flush,
    input  pc_wr, ifid_wr, idex_bubble, md_start, md_busy, stall_cnt
  );

  modport slave (
    input  op_id, func_id, Rs_id, Rt_id, op_ex, Rw_ex, flush,
    output pc_wr, ifid_wr, idex_bubble, md_start, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_interlock.sv
// rtl/pipe_interlock.sv - load-use and mult/div interlock with saturating stall counter
module pipe_interlock #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input logic            clk,
  input logic            rst,
  pipe_interlock_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [5:0]       MD_LOAD = 6'(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             is_r;
  logic             is_jr;
  logic             is_md;
  logic             is_hl;
  logic             uses_rt;
  logic             ld_haz;
  logic             md_haz;
  logic             stall;
  logic             md_busy;
  logic             md_start;
  logic [5:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    is_r    = (bus.op_id == OP_RTYPE);
    is_jr   = is_r && ((bus.func_id == FN_JR) || (bus.func_id == FN_JALR));
    is_md   = is_r && (bus.func_id[5:2] == 4'b0110);
    is_hl   = is_r && ((bus.func_id == FN_MFHI) || (bus.func_id == FN_MFLO));
    uses_rt = (bus.op_id == OP_BEQ) || (bus.op_id == OP_BNE) || (bus.op_id == OP_SW) ||
              (is_r && !is_hl && !is_jr);

    // rs is compared for every ID instruction; r0 never matches so the bubble cannot self-stall
    ld_haz  = (bus.op_ex == OP_LW) && (bus.Rw_ex != 5'd0) &&
              ((bus.Rs_id == bus.Rw_ex) || (uses_rt && (bus.Rt_id == bus.Rw_ex)));
    md_busy = (md_cnt_q != 6'd0);
    md_haz  = md_busy && (is_md || is_hl);
    stall   = (ld_haz || md_haz) && !bus.flush;
    md_start = is_md && !stall && !bus.flush;
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = MD_LOAD;
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - 6'd1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q    <= 6'd0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_wr       = !stall;
  assign bus.ifid_wr     = !stall;
  assign bus.idex_bubble = stall || bus.flush;
  assign bus.md_start    = md_start;
  assign bus.md_busy     = md_busy;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_interlock.sv
// tb/tb_pipe_interlock.sv - randomized scoreboard bench for pipe_interlock
module tb_pipe_interlock;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    int       cyc;
    logic     pc_wr;
    logic     ifid_wr;
    logic     bubble;
    logic     md_start;
    logic     md_busy;
    int       cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_interlock_if #(.CNT_W(CNT_W)) bus ();

  pipe_interlock #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference state: cycle number, first cycle the MD unit is free again, stalls so far.
  int m_cycle    = 0;
  int m_md_ready = 0;
  int m_stalls   = 0;

  function automatic bit f_md(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn >= 6'h18) && (fn <= 6'h1b);
  endfunction

  function automatic bit f_hl(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && ((fn == 6'h10) || (fn == 6'h12));
  endfunction

  function automatic bit f_uses_rt(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h04, 6'h05, 6'h2b: return 1'b1;
      6'h00:               return !f_hl(op, fn) && (fn != 6'h08) && (fn != 6'h09);
      default:             return 1'b0;
    endcase
  endfunction

  task automatic cmp(input string name, input int cyc, input int got, input int want);
    tests++;
    if (got != want) begin
      failed++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  task automatic drv(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [5:0] opx, input logic [4:0] rw,
                     input logic fl, input bit chk);
    exp_t e;
    bit busy, ld, mdh, st, start;
    @(posedge clk);
    #1;
    rst = r;
    bus.op_id = op;  bus.func_id = fn; bus.Rs_id = rs; bus.Rt_id = rt;
    bus.op_ex = opx; bus.Rw_ex = rw;   bus.flush = fl;

    busy  = (m_cycle < m_md_ready);
    ld    = (opx == 6'h23) && (rw != 0) && ((rs == rw) || (f_uses_rt(op, fn) && (rt == rw)));
    mdh   = busy && (f_md(op, fn) || f_hl(op, fn));
    st    = (ld || mdh) && !fl;
    start = f_md(op, fn) && !st && !fl;

    e.cyc = m_cycle; e.pc_wr = !st; e.ifid_wr = !st; e.bubble = st || fl;
    e.md_start = start; e.md_busy = busy; e.cnt = m_stalls;
    if (chk) q.push_back(e);

    if (r) begin
      m_md_ready = 0;
      m_stalls   = 0;
    end else begin
      if (start) m_md_ready = m_cycle + 1 + MD_LAT;
      if (st && m_stalls < CMAX) m_stalls++;
    end
    m_cycle++;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 6'h00, 6'h20, 5'd0, 5'd0, 6'h00, 5'd0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("pc_wr",       e.cyc, int'(bus.pc_wr),       int'(e.pc_wr));
      cmp("ifid_wr",     e.cyc, int'(bus.ifid_wr),     int'(e.ifid_wr));
      cmp("idex_bubble", e.cyc, int'(bus.idex_bubble), int'(e.bubble));
      cmp("md_start",    e.cyc, int'(bus.md_start),    int'(e.md_start));
      cmp("md_busy",     e.cyc, int'(bus.md_busy),     int'(e.md_busy));
      cmp("stall_cnt",   e.cyc, int'(bus.stall_cnt),   e.cnt);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops [11];
    logic [5:0] fns [10];
    ops = '{6'h00, 6'h00, 6'h00, 6'h04, 6'h05, 6'h01, 6'h06, 6'h07, 6'h08, 6'h23, 6'h2b};
    fns = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h08, 6'h09, 6'h20, 6'h2a};

    // reset, then reset values
    drv(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 6'h00, 5'd0, 1'b0, 1'b0);
    nop(1);

    // load-use on beq, one cycle, then forwarding takes over
    drv(1'b0, 6'h04, 6'h00, 5'd5, 5'd0, 6'h23, 5'd5, 1'b0, 1'b1);
    drv(1'b0, 6'h04, 6'h00, 5'd5, 5'd0, 6'h00, 5'd0, 1'b0, 1'b1);
    // Rw_ex = 0 and addi writing rt never stall
    drv(1'b0, 6'h00, 6'h20, 5'd0, 5'd0, 6'h23, 5'd0, 1'b0, 1'b1);
    drv(1'b0, 6'h08, 6'h00, 5'd1, 5'd5, 6'h23, 5'd5, 1'b0, 1'b1);

    // mult then mfhi held until the unit frees up
    drv(1'b0, 6'h00, 6'h18, 5'd1, 5'd2, 6'h00, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < MD_LAT + 1; i++)
      drv(1'b0, 6'h00, 6'h10, 5'd0, 5'd0, 6'h00, 5'd0, 1'b0, 1'b1);
    nop(2);

    // mult then back-to-back div
    drv(1'b0, 6'h00, 6'h18, 5'd1, 5'd2, 6'h00, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < MD_LAT + 1; i++)
      drv(1'b0, 6'h00, 6'h1a, 5'd3, 5'd4, 6'h00, 5'd0, 1'b0, 1'b1);
    nop(MD_LAT + 1);

    // flush overrides load-use; flushed mult never starts
    drv(1'b0, 6'h00, 6'h20, 5'd7, 5'd0, 6'h23, 5'd7, 1'b1, 1'b1);
    drv(1'b0, 6'h00, 6'h18, 5'd1, 5'd2, 6'h00, 5'd0, 1'b1, 1'b1);
    nop(1);

    // reset while mfhi waits on a partially elapsed countdown
    drv(1'b0, 6'h00, 6'h18, 5'd1, 5'd2, 6'h00, 5'd0, 1'b0, 1'b1);
    drv(1'b0, 6'h00, 6'h12, 5'd0, 5'd0, 6'h00, 5'd0, 1'b0, 1'b1);
    drv(1'b1, 6'h00, 6'h12, 5'd0, 5'd0, 6'h00, 5'd0, 1'b0, 1'b1);
    drv(1'b0, 6'h00, 6'h12, 5'd0, 5'd0, 6'h00, 5'd0, 1'b0, 1'b1);
    nop(1);

    // saturation of the 4-bit stall counter
    for (int i = 0; i < CMAX + 4; i++)
      drv(1'b0, 6'h2b, 6'h00, 5'd1, 5'd9, 6'h23, 5'd9, 1'b0, 1'b1);
    nop(2);

    for (int i = 0; i < 2500; i++) begin
      drv(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
          ops[$urandom_range(0, 10)], fns[$urandom_range(0, 9)],
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1) ? 6'h23 : 6'($urandom_range(0, 63)),
          5'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 1'b1);
    end

    nop(1);
    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_drained", m_cycle, q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
